// File: rtl/uart_tx_fifo_if.sv
// Handshake bundle for uart_tx_fifo: controller write port, occupancy flags and
// the TX_EN/TX_STATUS request pair toward the UART sender.
interface uart_tx_fifo_if #(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned DATA_W     = 8
);
    logic [DATA_W-1:0]   wr_data;
    logic                wr_en;
    logic                full;
    logic                empty;
    logic [DEPTH_LOG2:0] count;
    logic                TX_STATUS;
    logic [DATA_W-1:0]   TX_DATA;
    logic                TX_EN;
    logic                overflow;

    // master: controller + sender side
    modport master (
        output wr_data, wr_en, TX_STATUS,
        input  full, empty, count, TX_DATA, TX_EN, overflow
    );

    // slave: the FIFO itself
    modport slave (
        input  wr_data, wr_en, TX_STATUS,
        output full, empty, count, TX_DATA, TX_EN, overflow
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO between UART controller and the baudclk-domain sender, holding TX_EN until acknowledged.
// Optional sticky overflow flag enabled by defining UART_TX_FIFO_OVF_EN.
module uart_tx_fifo #(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned DATA_W     = 8
) (
    input  logic          sysclk,
    input  logic          reset,
    uart_tx_fifo_if.slave bus
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;
    localparam int unsigned PW    = DEPTH_LOG2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        BUSY = 2'd2
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     count_nxt;
    logic              full_q;
    logic              empty_q;
    logic              tx_en_q;
    logic [DATA_W-1:0] tx_data_q;
    logic              ovf_q;
    logic              ts_meta;
    logic              ts_s;
    logic              do_wr;
    logic              do_pop;

    // TX_STATUS comes from the baudclk domain
    always_ff @(posedge sysclk) begin
        ts_meta <= bus.TX_STATUS;
        ts_s    <= ts_meta;
    end

    // Write uses registered full, so a same-cycle pop never frees room for it
    always_comb begin
        do_wr     = bus.wr_en && !full_q;
        do_pop    = (state == BUSY) && ts_s;
        count_nxt = count_q;
        if (do_wr && !do_pop) begin
            count_nxt = count_q + CW'(1);
        end else if (!do_wr && do_pop) begin
            count_nxt = count_q - CW'(1);
        end
    end

    always_ff @(posedge sysclk) begin
        if (do_wr) begin
            mem[wr_ptr] <= bus.wr_data;
        end
    end

    // Pointers, occupancy and the IDLE/REQ/BUSY request handshake
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
            tx_en_q   <= 1'b0;
            tx_data_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count_q <= count_nxt;
            empty_q <= (count_nxt == '0);
            full_q  <= (count_nxt == CW'(DEPTH));

            // The byte stays at rd_ptr until the sender finishes it
            case (state)
                IDLE: begin
                    if ((count_q != '0) && ts_s) begin
                        tx_data_q <= mem[rd_ptr];
                        tx_en_q   <= 1'b1;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (!ts_s) begin
                        tx_en_q <= 1'b0;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (ts_s) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    tx_en_q <= 1'b0;
                    state   <= IDLE;
                end
            endcase

`ifdef UART_TX_FIFO_OVF_EN
            if (bus.wr_en && full_q) begin
                ovf_q <= 1'b1;
            end
`else
            ovf_q <= 1'b0;
`endif
        end
    end

    assign bus.count    = count_q;
    assign bus.empty    = empty_q;
    assign bus.full     = full_q;
    assign bus.TX_EN    = tx_en_q;
    assign bus.TX_DATA  = tx_data_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: fill/overflow vector table, TX_EN scoreboard and a
// baudclk-driven sender model (baud rate scaled down to keep the run short).
`timescale 1ns/1ps
module tb_uart_tx_fifo;
    localparam int unsigned DEPTH_LOG2 = 4;
    localparam int unsigned DEPTH      = 1 << DEPTH_LOG2;
`ifdef UART_TX_FIFO_OVF_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    typedef struct {
        logic       wr_en;
        logic [7:0] data;
        logic       accept;
        logic [4:0] exp_count;
        logic       exp_full;
        logic       exp_empty;
    } vec_t;

    logic       sysclk      = 1'b0;
    logic       baudclk     = 1'b0;
    logic       reset;
    logic       auto_mode;
    logic       ts_manual;
    logic       ts_auto     = 1'b1;
    int         busy_cnt    = 0;
    int         captured    = 0;
    int         frame_ticks;
    int         rises;
    int         checks;
    int         errors;
    logic [7:0] sb[$];
    vec_t       vecs[18];

    uart_tx_fifo_if #(.DEPTH_LOG2(DEPTH_LOG2), .DATA_W(8)) bus ();

    uart_tx_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .DATA_W(8)) dut (
        .sysclk(sysclk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.TX_STATUS = auto_mode ? ts_auto : ts_manual;

    always #10 sysclk = ~sysclk;

    // Period unrelated to sysclk so TX_STATUS edges land anywhere in the cycle
    initial begin
        #3;
        forever #18.65 baudclk = ~baudclk;
    end

    // Sender: take a byte when idle and TX_EN is up, stay busy for frame_ticks
    always @(posedge baudclk) begin
        if (!auto_mode) begin
            ts_auto  = 1'b1;
            busy_cnt = 0;
        end else if (busy_cnt != 0) begin
            busy_cnt--;
            if (busy_cnt == 0) ts_auto = 1'b1;
        end else if (bus.TX_EN === 1'b1 && ts_auto) begin
            captured++;
            ts_auto  = 1'b0;
            busy_cnt = frame_ticks;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Each TX_EN assertion must present the oldest byte still owed
    task automatic monitor();
        logic       prev;
        logic [7:0] e;
        prev = 1'b0;
        forever begin
            @(posedge sysclk);
            #1;
            if (bus.TX_EN === 1'b1 && !prev) begin
                rises++;
                if (sb.size() == 0) begin
                    check("tx_unexpected_byte", 32'(bus.TX_DATA), 32'h100);
                end else begin
                    e = sb.pop_front();
                    check("tx_data_order", 32'(bus.TX_DATA), 32'(e));
                end
            end
            prev = (bus.TX_EN === 1'b1);
        end
    endtask

    task automatic push_write(input logic [7:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_data = d;
        sb.push_back(d);
        @(negedge sysclk);
        bus.wr_en   = 1'b0;
    endtask

    task automatic wait_tx_en(input logic lvl, input int limit, output int n);
        n = 0;
        while (bus.TX_EN !== lvl && n < limit) begin
            @(negedge sysclk);
            n++;
        end
    endtask

    task automatic wait_drain(input int expect_cap, input int limit);
        int n = 0;
        while ((captured < expect_cap || bus.empty !== 1'b1 || bus.TX_EN !== 1'b0) && n < limit) begin
            @(negedge sysclk);
            n++;
        end
        check("drain_captured", 32'(captured), 32'(expect_cap));
        check("drain_sb_empty", 32'(sb.size()), 32'd0);
        check("drain_empty", 32'(bus.empty), 32'd1);
    endtask

    // Keep at most 14 bytes unacknowledged so no write can hit a full FIFO
    task automatic stream(input int nbytes, input int max_gap);
        int sent  = 0;
        int cap0  = captured;
        int guard = 0;
        while (sent < nbytes && guard < 20000) begin
            if ((sent - (captured - cap0)) < 14) begin
                check("count_le_depth", 32'(int'(bus.count) <= int'(DEPTH)), 32'd1);
                push_write(8'($urandom));
                sent++;
                repeat ($urandom_range(0, max_gap)) @(negedge sysclk);
            end else begin
                @(negedge sysclk);
            end
            guard++;
        end
        wait_drain(cap0 + nbytes, 30000);
    endtask

    initial begin
        int n;
        int r0;
        int cap0;

        for (int i = 0; i < 16; i++) begin
            vecs[i] = '{1'b1, 8'(i), 1'b1, 5'(i + 1), (i == 15), 1'b0};
        end
        vecs[16] = '{1'b1, 8'hAA, 1'b0, 5'd16, 1'b1, 1'b0};
        vecs[17] = '{1'b0, 8'h00, 1'b0, 5'd16, 1'b1, 1'b0};

        reset       = 1'b1;
        auto_mode   = 1'b0;
        ts_manual   = 1'b1;
        frame_ticks = 4;
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        checks      = 0;
        errors      = 0;
        rises       = 0;
        fork
            monitor();
        join_none

        repeat (3) @(negedge sysclk);
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_empty", 32'(bus.empty), 32'd1);
        check("rst_full", 32'(bus.full), 32'd0);
        check("rst_tx_en", 32'(bus.TX_EN), 32'd0);
        check("rst_tx_data", 32'(bus.TX_DATA), 32'd0);
        check("rst_overflow", 32'(bus.overflow), 32'd0);
        reset = 1'b0;
        repeat (4) @(negedge sysclk);

        // Single byte: latency, TX_EN release, pop on sender idle
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'h41;
        sb.push_back(8'h41);
        @(negedge sysclk);
        bus.wr_en = 1'b0;
        check("lat_tx_en_early", 32'(bus.TX_EN), 32'd0);
        @(negedge sysclk);
        check("lat_tx_en", 32'(bus.TX_EN), 32'd1);
        check("lat_tx_data", 32'(bus.TX_DATA), 32'h41);
        ts_manual = 1'b0;
        wait_tx_en(1'b0, 10, n);
        check("tx_en_fall", 32'(bus.TX_EN), 32'd0);
        check("tx_en_fall_cycles", 32'(n <= 3), 32'd1);
        repeat (97) @(negedge sysclk);
        check("busy_tx_data_stable", 32'(bus.TX_DATA), 32'h41);
        ts_manual = 1'b1;
        repeat (4) @(negedge sysclk);
        check("pop_count", 32'(bus.count), 32'd0);
        check("pop_empty", 32'(bus.empty), 32'd1);
        check("single_rise", 32'(rises), 32'd1);

        // Fill to full with sender busy, then one rejected write
        ts_manual = 1'b0;
        repeat (3) @(negedge sysclk);
        r0 = rises;
        for (int i = 0; i < 18; i++) begin
            bus.wr_en   = vecs[i].wr_en;
            bus.wr_data = vecs[i].data;
            if (vecs[i].accept) sb.push_back(vecs[i].data);
            @(negedge sysclk);
            check($sformatf("tbl_count[%0d]", i), 32'(bus.count), 32'(vecs[i].exp_count));
            check($sformatf("tbl_full[%0d]", i), 32'(bus.full), 32'(vecs[i].exp_full));
            check($sformatf("tbl_empty[%0d]", i), 32'(bus.empty), 32'(vecs[i].exp_empty));
        end
        bus.wr_en = 1'b0;
        check("ovf_after_reject", 32'(bus.overflow), 32'(OVF_EXP));
        check("no_tx_while_busy", 32'(rises), 32'(r0));
        cap0      = captured;
        auto_mode = 1'b1;
        wait_drain(cap0 + 16, 3000);
        check("fill_one_rise_each", 32'(rises), 32'(r0 + 16));
        check("ovf_persists", 32'(bus.overflow), 32'(OVF_EXP));

        // Streaming through several pointer wraps
        stream(40, 3);

        // Write lands on the exact pop edge: count must not move
        ts_manual = 1'b1;
        auto_mode = 1'b0;
        @(negedge sysclk);
        push_write(8'h11);
        push_write(8'h22);
        wait_tx_en(1'b1, 10, n);
        check("sc_tx_en", 32'(bus.TX_EN), 32'd1);
        ts_manual = 1'b0;
        wait_tx_en(1'b0, 10, n);
        check("sc_busy", 32'(bus.TX_EN), 32'd0);
        check("sc_count_before", 32'(bus.count), 32'd2);
        ts_manual = 1'b1;
        repeat (2) @(negedge sysclk);
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'h33;
        sb.push_back(8'h33);
        @(negedge sysclk);
        bus.wr_en = 1'b0;
        check("sc_count_same_cycle", 32'(bus.count), 32'd2);
        cap0      = captured;
        auto_mode = 1'b1;
        wait_drain(cap0 + 2, 3000);

        // Reset while a request is pending with bytes queued
        ts_manual = 1'b1;
        auto_mode = 1'b0;
        @(negedge sysclk);
        for (int i = 0; i < 5; i++) push_write(8'hC0 + 8'(i));
        wait_tx_en(1'b1, 10, n);
        check("rr_tx_en_req", 32'(bus.TX_EN), 32'd1);
        reset = 1'b1;
        @(negedge sysclk);
        check("rr_tx_en", 32'(bus.TX_EN), 32'd0);
        check("rr_count", 32'(bus.count), 32'd0);
        check("rr_empty", 32'(bus.empty), 32'd1);
        check("rr_full", 32'(bus.full), 32'd0);
        check("rr_overflow", 32'(bus.overflow), 32'd0);
        reset = 1'b0;
        sb.delete();
        r0 = rises;
        repeat (30) @(negedge sysclk);
        check("rr_no_resend", 32'(rises), 32'(r0));
        push_write(8'h5A);
        wait_tx_en(1'b1, 10, n);
        check("rr_new_tx_en", 32'(bus.TX_EN), 32'd1);
        cap0      = captured;
        auto_mode = 1'b1;
        wait_drain(cap0 + 1, 3000);

        // Long random stream with slower frames
        frame_ticks = 10;
        stream(256, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
